// File: rtl/serv_mem_pkg.sv
// Shared types for the SERV RAM responder.
//   state_e : responder FSM states (IDLE -> RESP -> GUARD -> IDLE)
//   grant_e : which requester owns the transaction in flight
//   LaneW   : width of the byte-lane index inside a 32-bit word
package serv_mem_pkg;

  localparam int unsigned LaneW = 2;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    GUARD
  } state_e;

  typedef enum logic [1:0] {
    G_NONE,
    G_IBUS,
    G_DBUS,
    G_HOST
  } grant_e;

endpackage

// File: rtl/serv_byte_lane.sv
// Byte steering between the 8-bit host port and the 32-bit RAM word.
//   lane_i     : byte index within the word (host adr[1:0])
//   wr_byte_i  : host write byte
//   rd_word_i  : RAM read word
//   wr_word_o  : write byte shifted into its lane, other lanes zero
//   wr_be_o    : one-hot byte enable for the selected lane
//   rd_byte_o  : selected byte of the read word
module serv_byte_lane
  import serv_mem_pkg::*;
(
  input  logic [LaneW-1:0] lane_i,
  input  logic [7:0]       wr_byte_i,
  input  logic [31:0]      rd_word_i,
  output logic [31:0]      wr_word_o,
  output logic [3:0]       wr_be_o,
  output logic [7:0]       rd_byte_o
);

  logic [4:0] bit_shift;

  assign bit_shift = {lane_i, 3'b000};
  assign wr_word_o = {24'b0, wr_byte_i} << bit_shift;
  assign wr_be_o   = 4'b0001 << lane_i;
  assign rd_byte_o = rd_word_i[bit_shift +: 8];

endmodule

// File: rtl/serv_ram_responder.sv
// Serves SERV ibus, SERV dbus and a host byte port from one single-port RAM32 macro
// (1-cycle read latency). One transaction in flight: IDLE grants (host > dbus > ibus)
// and drives the RAM, RESP pulses the ack with read data, GUARD gives SERV a cycle to
// drop cyc before the next grant.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   i_ibus_*, o_ibus_*              instruction bus (read only)
//   i_dbus_*, o_dbus_*              data bus (read / byte-masked write)
//   i_host_*, o_host_*              host byte port
//   o_ram_*, i_ram_do               RAM32 macro interface
//   o_oob                           sticky out-of-range ibus/dbus access flag
module serv_ram_responder
  import serv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ibus_cyc,
  input  logic [31:0]       i_ibus_adr,
  output logic [31:0]       o_ibus_rdt,
  output logic              o_ibus_ack,
  input  logic              i_dbus_cyc,
  input  logic [31:0]       i_dbus_adr,
  input  logic              i_dbus_we,
  input  logic [31:0]       i_dbus_dat,
  input  logic [3:0]        i_dbus_sel,
  output logic [31:0]       o_dbus_rdt,
  output logic              o_dbus_ack,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W+1:0] i_host_adr,
  input  logic [7:0]        i_host_dat,
  output logic [7:0]        o_host_rdat,
  output logic              o_host_ack,
  output logic              o_ram_en,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic [3:0]        o_ram_we,
  output logic [31:0]       o_ram_di,
  input  logic [31:0]       i_ram_do,
  output logic              o_oob
);

  state_e           state_q;
  grant_e           grant_q, grant_d;
  logic [LaneW-1:0] lane_q;
  logic             wr_q, wr_d;
  logic             oob_hit_q, oob_hit_d;
  logic             oob_q;

  logic             ibus_in_range, dbus_in_range;
  logic [31:0]      host_di;
  logic [3:0]       host_we;
  logic [7:0]       host_rd_byte;
  logic             resp_live;

  // Word-aligned buses: the byte offset bits are ignored.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_ibus_adr[1:0], i_dbus_adr[1:0]};

  assign ibus_in_range = (i_ibus_adr[31:ADDR_W+2] == MEM_BASE[31:ADDR_W+2]);
  assign dbus_in_range = (i_dbus_adr[31:ADDR_W+2] == MEM_BASE[31:ADDR_W+2]);

  serv_byte_lane u_byte_lane (
    .lane_i    (state_q == IDLE ? i_host_adr[1:0] : lane_q),
    .wr_byte_i (i_host_dat),
    .rd_word_i (i_ram_do),
    .wr_word_o (host_di),
    .wr_be_o   (host_we),
    .rd_byte_o (host_rd_byte)
  );

  // Grant decode and RAM drive; RAM is addressed in the same cycle the grant is taken.
  always_comb begin
    grant_d   = G_NONE;
    wr_d      = 1'b0;
    oob_hit_d = 1'b0;
    o_ram_en  = 1'b0;
    o_ram_a   = '0;
    o_ram_we  = 4'b0000;
    o_ram_di  = 32'h0;
    if (state_q == IDLE) begin
      if (i_host_req) begin
        grant_d  = G_HOST;
        wr_d     = i_host_we;
        o_ram_en = 1'b1;
        o_ram_a  = i_host_adr[ADDR_W+1:2];
        if (i_host_we) begin
          o_ram_we = host_we;
          o_ram_di = host_di;
        end
      end else if (i_dbus_cyc) begin
        grant_d = G_DBUS;
        wr_d    = i_dbus_we;
        if (dbus_in_range) begin
          o_ram_en = 1'b1;
          o_ram_a  = i_dbus_adr[ADDR_W+1:2];
          if (i_dbus_we) begin
            o_ram_we = i_dbus_sel;
            o_ram_di = i_dbus_dat;
          end
        end else begin
          oob_hit_d = 1'b1;
        end
      end else if (i_ibus_cyc) begin
        grant_d = G_IBUS;
        if (ibus_in_range) begin
          o_ram_en = 1'b1;
          o_ram_a  = i_ibus_adr[ADDR_W+1:2];
        end else begin
          oob_hit_d = 1'b1;
        end
      end
    end
    // Reset must never reach the macro as a write, even with requests pending.
    if (!rst_n) begin
      o_ram_en = 1'b0;
      o_ram_we = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= G_NONE;
      lane_q    <= '0;
      wr_q      <= 1'b0;
      oob_hit_q <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_d != G_NONE) begin
            state_q   <= RESP;
            grant_q   <= grant_d;
            lane_q    <= i_host_adr[1:0];
            wr_q      <= wr_d;
            oob_hit_q <= oob_hit_d;
            if (oob_hit_d) oob_q <= 1'b1;
          end
        end
        RESP: begin
          state_q <= GUARD;
        end
        GUARD: begin
          state_q <= IDLE;
          grant_q <= G_NONE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= G_NONE;
        end
      endcase
    end
  end

  // Ack is decoded from registered state; gating with rst_n drops an ack whose
  // RESP cycle coincides with reset.
  assign resp_live   = rst_n && (state_q == RESP);
  assign o_ibus_ack  = resp_live && (grant_q == G_IBUS);
  assign o_dbus_ack  = resp_live && (grant_q == G_DBUS);
  assign o_host_ack  = resp_live && (grant_q == G_HOST);

  assign o_ibus_rdt  = (o_ibus_ack && !oob_hit_q) ? i_ram_do : 32'h0;
  assign o_dbus_rdt  = (o_dbus_ack && !oob_hit_q && !wr_q) ? i_ram_do : 32'h0;
  assign o_host_rdat = (o_host_ack && !wr_q) ? host_rd_byte : 8'h00;
  assign o_oob       = oob_q;

endmodule

// File: tb/tb_serv_ram_responder.sv
module tb_serv_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ibus_cyc = 1'b0;
  logic [31:0] ibus_adr = 32'h0;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic        dbus_cyc = 1'b0;
  logic [31:0] dbus_adr = 32'h0;
  logic        dbus_we = 1'b0;
  logic [31:0] dbus_dat = 32'h0;
  logic [3:0]  dbus_sel = 4'h0;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [6:0]  host_adr = 7'h0;
  logic [7:0]  host_dat = 8'h0;
  logic [7:0]  host_rdat;
  logic        host_ack;
  logic        ram_en;
  logic [4:0]  ram_a;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_do = 32'h0;
  logic        oob;

  // RAM32 model with a side-door loader for preloading.
  logic [31:0] mem [32];
  logic        load_en = 1'b0;
  logic [4:0]  load_a = 5'h0;
  logic [31:0] load_d = 32'h0;

  int total = 0;
  int bad = 0;

  int          h_at, d_at, i_at, n_acks;
  logic [7:0]  h_rd;
  logic [31:0] d_rd, i_rd;

  serv_ram_responder #(
    .ADDR_W   (5),
    .MEM_BASE (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ibus_cyc  (ibus_cyc),
    .i_ibus_adr  (ibus_adr),
    .o_ibus_rdt  (ibus_rdt),
    .o_ibus_ack  (ibus_ack),
    .i_dbus_cyc  (dbus_cyc),
    .i_dbus_adr  (dbus_adr),
    .i_dbus_we   (dbus_we),
    .i_dbus_dat  (dbus_dat),
    .i_dbus_sel  (dbus_sel),
    .o_dbus_rdt  (dbus_rdt),
    .o_dbus_ack  (dbus_ack),
    .i_host_req  (host_req),
    .i_host_we   (host_we),
    .i_host_adr  (host_adr),
    .i_host_dat  (host_dat),
    .o_host_rdat (host_rdat),
    .o_host_ack  (host_ack),
    .o_ram_en    (ram_en),
    .o_ram_a     (ram_a),
    .o_ram_we    (ram_we),
    .o_ram_di    (ram_di),
    .i_ram_do    (ram_do),
    .o_oob       (oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) begin
      mem[load_a] <= load_d;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      end
      ram_do <= mem[ram_a];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1;
    load_a  = a;
    load_d  = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Runs n cycles from a negedge, recording the cycle index of each ack and its data,
  // and drops each request once its ack has been seen.
  task automatic run_cycles(input int n);
    h_at = -1; d_at = -1; i_at = -1; n_acks = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (host_ack) begin
        n_acks++;
        if (h_at < 0) begin h_at = c; h_rd = host_rdat; end
        host_req = 1'b0;
      end
      if (dbus_ack) begin
        n_acks++;
        if (d_at < 0) begin d_at = c; d_rd = dbus_rdt; end
        dbus_cyc = 1'b0;
      end
      if (ibus_ack) begin
        n_acks++;
        if (i_at < 0) begin i_at = c; i_rd = ibus_rdt; end
        ibus_cyc = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset with clock running; preload the RAM model meanwhile.
    for (int w = 0; w < 32; w++) load_word(w[4:0], 32'h0);
    load_word(5'd1, 32'hDEAD_BEEF);
    load_word(5'd2, 32'hAAAA_BBBB);

    // A write request held during reset must not reach the RAM.
    @(negedge clk);
    dbus_cyc = 1'b1; dbus_we = 1'b1; dbus_adr = 32'h8; dbus_dat = 32'hFFFF_FFFF;
    dbus_sel = 4'hF;
    #1;
    check_eq("rst_ram_en", {31'b0, ram_en}, 32'h0);
    check_eq("rst_ram_we", {28'b0, ram_we}, 32'h0);
    @(negedge clk);
    check_eq("rst_acks", {29'b0, ibus_ack, dbus_ack, host_ack}, 32'h0);
    check_eq("rst_rdt", dbus_rdt | ibus_rdt, 32'h0);
    check_eq("rst_oob", {31'b0, oob}, 32'h0);
    dbus_cyc = 1'b0; dbus_we = 1'b0;
    rst_n = 1'b1;

    // ibus read of word 1.
    @(negedge clk);
    ibus_cyc = 1'b1; ibus_adr = 32'h4;
    #1;
    check_eq("ibus_ram_a", {27'b0, ram_a}, 32'h1);
    run_cycles(6);
    check_eq("ibus_lat", i_at, 1);
    check_eq("ibus_rdt", i_rd, 32'hDEAD_BEEF);
    check_eq("ibus_nacks", n_acks, 1);

    // dbus masked write then read back.
    dbus_cyc = 1'b1; dbus_we = 1'b1; dbus_adr = 32'h8; dbus_dat = 32'h1122_3344;
    dbus_sel = 4'b0101;
    #1;
    check_eq("dwr_ram_we", {28'b0, ram_we}, 32'h5);
    check_eq("dwr_ram_di", ram_di, 32'h1122_3344);
    run_cycles(6);
    check_eq("dwr_lat", d_at, 1);
    check_eq("dwr_rdt", d_rd, 32'h0);
    dbus_cyc = 1'b1; dbus_we = 1'b0;
    #1;
    check_eq("drd_ram_we", {28'b0, ram_we}, 32'h0);
    run_cycles(6);
    check_eq("drd_rdt", d_rd, 32'hAA22_BB44);

    // Host byte write to 0x0D then read back.
    host_req = 1'b1; host_we = 1'b1; host_adr = 7'h0D; host_dat = 8'h5A;
    #1;
    check_eq("hwr_ram_we", {28'b0, ram_we}, 32'h2);
    check_eq("hwr_ram_di", ram_di, 32'h0000_5A00);
    check_eq("hwr_ram_a", {27'b0, ram_a}, 32'h3);
    run_cycles(6);
    check_eq("hwr_lat", h_at, 1);
    check_eq("hwr_rdat", {24'b0, h_rd}, 32'h0);
    host_req = 1'b1; host_we = 1'b0;
    run_cycles(6);
    check_eq("hrd_rdat", {24'b0, h_rd}, 32'h5A);
    host_req = 1'b1; host_adr = 7'h0C;
    run_cycles(6);
    check_eq("hrd_lane0", {24'b0, h_rd}, 32'h0);

    // All three at once: host, then dbus, then ibus, 3 cycles apart.
    host_req = 1'b1; host_we = 1'b0; host_adr = 7'h0D;
    dbus_cyc = 1'b1; dbus_we = 1'b0; dbus_adr = 32'h8;
    ibus_cyc = 1'b1; ibus_adr = 32'h4;
    run_cycles(12);
    check_eq("arb_host_at", h_at, 1);
    check_eq("arb_dbus_at", d_at, 4);
    check_eq("arb_ibus_at", i_at, 7);
    check_eq("arb_nacks", n_acks, 3);
    check_eq("arb_host_rd", {24'b0, h_rd}, 32'h5A);
    check_eq("arb_dbus_rd", d_rd, 32'hAA22_BB44);
    check_eq("arb_ibus_rd", i_rd, 32'hDEAD_BEEF);

    // Out-of-range dbus read: no RAM access, zero data, sticky flag.
    check_eq("oob_before", {31'b0, oob}, 32'h0);
    dbus_cyc = 1'b1; dbus_we = 1'b0; dbus_adr = 32'h0000_1000;
    #1;
    check_eq("oob_ram_en", {31'b0, ram_en}, 32'h0);
    run_cycles(6);
    check_eq("oob_lat", d_at, 1);
    check_eq("oob_rdt", d_rd, 32'h0);
    check_eq("oob_flag", {31'b0, oob}, 32'h1);
    ibus_cyc = 1'b1; ibus_adr = 32'h4;
    run_cycles(6);
    check_eq("oob_sticky", {31'b0, oob}, 32'h1);

    // Reset during RESP of a dbus read.
    dbus_cyc = 1'b1; dbus_we = 1'b0; dbus_adr = 32'h4;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rmid_ack", {31'b0, dbus_ack}, 32'h0);
    check_eq("rmid_rdt", dbus_rdt, 32'h0);
    dbus_we = 1'b1; dbus_dat = 32'h0BAD_0BAD; dbus_sel = 4'hF;
    #1;
    check_eq("rmid_ram_en", {31'b0, ram_en}, 32'h0);
    check_eq("rmid_ram_we", {28'b0, ram_we}, 32'h0);
    @(negedge clk);
    check_eq("rmid_acks", {29'b0, ibus_ack, dbus_ack, host_ack}, 32'h0);
    check_eq("rmid_oob_clr", {31'b0, oob}, 32'h0);
    dbus_cyc = 1'b0; dbus_we = 1'b0;
    rst_n = 1'b1;
    // Immediate 1-cycle grant shows the FSM is back in IDLE; data shows no write leaked.
    ibus_cyc = 1'b1; ibus_adr = 32'h4;
    run_cycles(6);
    check_eq("rpost_lat", i_at, 1);
    check_eq("rpost_rdt", i_rd, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
